// File: rtl/regbank_read_seq_if.sv
// Request/response handshake bundle for the register-bank read sequencer.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The source holds valid and its payload
// stable until that edge. Ready may depend combinationally on state but never
// on valid.
//
// Signals:
//   req_valid / req_ready / req_addr1 / req_addr2 : read request channel
//   rsp_valid / rsp_ready / rsp_data1 / rsp_data2 : read response channel
// Modports:
//   master : the requester (drives the request, consumes the response)
//   slave  : the sequencer (accepts the request, produces the response)
interface regbank_read_seq_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr1;
  logic [ADDR_W-1:0] req_addr2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data1;
  logic [DATA_W-1:0] rsp_data2;

  modport master (
    output req_valid, req_addr1, req_addr2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_addr1, req_addr2, rsp_ready,
    output req_ready, rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/regbank_read_seq.sv
// Read-side sequencer for a bank of tristate-bitline registers sharing two
// read bitline buses. A dual-address request raises one-hot read enables for
// two cycles (DRIVE, CAPTURE), samples both bitlines at the end of CAPTURE,
// and returns the pair on the response channel. A write landing on the
// capture edge to a read address is bypassed so the response never lags it.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   bus (slave modport)      : request/response handshake bundle
//   ReadEnable1/ReadEnable2  : one-hot read enables into the bank (registered)
//   Bitline1/Bitline2        : shared bitline buses from the bank
//   wr_en/wr_addr/wr_data    : bank write strobe, observed for the bypass
//   dbg_state                : current FSM state (IDLE=0 DRIVE=1 CAPTURE=2 RESP=3)
module regbank_read_seq #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 9
) (
  input  logic                clk,
  input  logic                rst,
  regbank_read_seq_if.slave   bus,
  output logic [NUM_REGS-1:0] ReadEnable1,
  output logic [NUM_REGS-1:0] ReadEnable2,
  input  logic [DATA_W-1:0]   Bitline1,
  input  logic [DATA_W-1:0]   Bitline2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr1_q, addr2_q;
  logic                accept;
  logic                en_active_n;
  logic [ADDR_W-1:0]   sel1, sel2;
  logic [NUM_REGS-1:0] en1_n, en2_n;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data1_q, rsp_data2_q;
  logic [DATA_W-1:0]   cap1, cap2;

  // Next-state and next-enable logic. Enables are computed from the next
  // state and registered, so the bank sees glitch-free flop outputs that do
  // not follow the request inputs combinationally.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_n = DRIVE;
          accept  = 1'b1;
        end
      end
      DRIVE:   state_n = CAPTURE;
      CAPTURE: state_n = RESP;
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // On the accept edge the latches are not yet loaded, so decode directly
    // from the request address.
    sel1        = accept ? bus.req_addr1 : addr1_q;
    sel2        = accept ? bus.req_addr2 : addr2_q;
    en_active_n = (state_n == DRIVE) || (state_n == CAPTURE);
    en1_n       = en_active_n ? (NUM_REGS'(1) << sel1) : '0;
    en2_n       = en_active_n ? (NUM_REGS'(1) << sel2) : '0;

    // Same-edge write bypass: the register only commits on this edge, so the
    // bitlines still show the old value.
    cap1 = (wr_en && (wr_addr == addr1_q)) ? wr_data : Bitline1;
    cap2 = (wr_en && (wr_addr == addr2_q)) ? wr_data : Bitline2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr1_q     <= '0;
      addr2_q     <= '0;
      ReadEnable1 <= '0;
      ReadEnable2 <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      state       <= state_n;
      ReadEnable1 <= en1_n;
      ReadEnable2 <= en2_n;
      if (accept) begin
        addr1_q <= bus.req_addr1;
        addr2_q <= bus.req_addr2;
      end
      // Bitlines are only meaningful while enables are up; sample in CAPTURE.
      if (state == CAPTURE) begin
        rsp_data1_q <= cap1;
        rsp_data2_q <= cap2;
      end
      rsp_valid_q <= (state_n == RESP);
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_data2 = rsp_data2_q;
  assign dbg_state     = state;

  // Enable vectors are one-hot-or-zero, and zero outside DRIVE/CAPTURE.
  a_en_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(ReadEnable1) && $onehot0(ReadEnable2));
  a_en_idle: assert property (@(posedge clk) disable iff (rst)
    ((state == IDLE) || (state == RESP)) |-> (ReadEnable1 == '0 && ReadEnable2 == '0));

endmodule

// File: tb/tb_regbank_read_seq.sv
module tb_regbank_read_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ReadEnable1, ReadEnable2;
  logic [8:0]  Bitline1, Bitline2;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [8:0]  wr_data = '0;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  regbank_read_seq_if #(.ADDR_W(4), .DATA_W(9)) bus ();

  regbank_read_seq #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(9)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
    .Bitline1(Bitline1), .Bitline2(Bitline2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register bank model ----------------
  logic [8:0] regs [16] = '{default: 9'h000};

  always @(posedge clk) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  always_comb begin
    Bitline1 = 'z;
    Bitline2 = 'z;
    for (int i = 0; i < 16; i++) begin
      if (ReadEnable1[i]) Bitline1 = regs[i];
      if (ReadEnable2[i]) Bitline2 = regs[i];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_reg(input logic [3:0] a, input logic [8:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge inside DRIVE (one edge after acceptance).
  task automatic send_req(input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr1 = a1; bus.req_addr2 = a2;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #12;
    total_cnt++; if (ReadEnable1 !== 16'h0) $display("FAIL reset_en1: got %h expected 0000", ReadEnable1); else pass_cnt++;
    total_cnt++; if (ReadEnable2 !== 16'h0) $display("FAIL reset_en2: got %h expected 0000", ReadEnable2); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_data1 !== 9'h0 || bus.rsp_data2 !== 9'h0) $display("FAIL reset_data: got %h/%h expected 000/000", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.rsp_ready = 1'b1;
    write_reg(4'd3, 9'h1A5);
    write_reg(4'd7, 9'h05A);
    send_req(4'd3, 4'd7);
    // DRIVE
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL basic_ready_drive: got %b expected 0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (ReadEnable1 !== 16'h0008 || ReadEnable2 !== 16'h0080) $display("FAIL basic_en_drive: got %h/%h expected 0008/0080", ReadEnable1, ReadEnable2); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_valid_drive: got %b expected 0", bus.rsp_valid); else pass_cnt++;
    @(negedge clk); // CAPTURE
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL basic_ready_capture: got %b expected 0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (ReadEnable1 !== 16'h0008 || ReadEnable2 !== 16'h0080) $display("FAIL basic_en_capture: got %h/%h expected 0008/0080", ReadEnable1, ReadEnable2); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_valid_capture: got %b expected 0", bus.rsp_valid); else pass_cnt++;
    @(negedge clk); // RESP
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL basic_ready_resp: got %b expected 0", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL basic_valid_resp: got %b expected 1", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_data1 !== 9'h1A5 || bus.rsp_data2 !== 9'h05A) $display("FAIL basic_data: got %h/%h expected 1a5/05a", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    total_cnt++; if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) $display("FAIL basic_en_resp: got %h/%h expected 0000/0000", ReadEnable1, ReadEnable2); else pass_cnt++;
    @(negedge clk); // back in IDLE
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_valid_idle: got %b expected 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL basic_ready_idle: got %b expected 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (bus.rsp_data1 !== 9'h1A5) $display("FAIL basic_data_hold: got %h expected 1a5", bus.rsp_data1); else pass_cnt++;
  endtask

  task automatic test_same_addr();
    write_reg(4'd5, 9'h1FF);
    send_req(4'd5, 4'd5);
    total_cnt++; if (ReadEnable1 !== 16'h0020 || ReadEnable2 !== 16'h0020) $display("FAIL same_en: got %h/%h expected 0020/0020", ReadEnable1, ReadEnable2); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.rsp_data1 !== 9'h1FF || bus.rsp_data2 !== 9'h1FF) $display("FAIL same_data: got %h/%h expected 1ff/1ff", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_capture_bypass();
    write_reg(4'd9, 9'h111);
    send_req(4'd2, 4'd9);
    @(negedge clk); // CAPTURE: write to read address 2
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 9'h0C3;
    @(negedge clk);
    wr_en = 1'b0;
    total_cnt++; if (bus.rsp_data1 !== 9'h0C3 || bus.rsp_data2 !== 9'h111) $display("FAIL bypass_data: got %h/%h expected 0c3/111", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
    // write in CAPTURE to an address not being read
    write_reg(4'd4, 9'h0AA);
    send_req(4'd4, 4'd6);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 9'h1F0;
    @(negedge clk);
    wr_en = 1'b0;
    total_cnt++; if (bus.rsp_data1 !== 9'h0AA || bus.rsp_data2 !== 9'h000) $display("FAIL bypass_other: got %h/%h expected 0aa/000", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_resp_write();
    write_reg(4'd2, 9'h000);
    send_req(4'd2, 4'd9);
    @(negedge clk);
    @(negedge clk); // RESP
    total_cnt++; if (bus.rsp_data1 !== 9'h000) $display("FAIL respwr_data: got %h expected 000", bus.rsp_data1); else pass_cnt++;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 9'h0C3;
    @(negedge clk);
    wr_en = 1'b0;
    total_cnt++; if (bus.rsp_data1 !== 9'h000) $display("FAIL respwr_snapshot: got %h expected 000", bus.rsp_data1); else pass_cnt++;
    send_req(4'd2, 4'd2);
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.rsp_data1 !== 9'h0C3 || bus.rsp_data2 !== 9'h0C3) $display("FAIL respwr_reread: got %h/%h expected 0c3/0c3", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_drive_and_accept_write();
    send_req(4'd10, 4'd11);
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 9'h155; // during DRIVE
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.rsp_data1 !== 9'h155 || bus.rsp_data2 !== 9'h000) $display("FAIL drivewr_data: got %h/%h expected 155/000", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
    // write in the accept cycle
    bus.req_valid = 1'b1; bus.req_addr1 = 4'd12; bus.req_addr2 = 4'd10;
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 9'h0F0;
    @(negedge clk);
    bus.req_valid = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.rsp_data1 !== 9'h0F0 || bus.rsp_data2 !== 9'h155) $display("FAIL acceptwr_data: got %h/%h expected 0f0/155", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    write_reg(4'd1, 9'h0A1);
    write_reg(4'd0, 9'h13C);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr1 = 4'd1; bus.req_addr2 = 4'd0;
    @(negedge clk); // DRIVE
    @(negedge clk); // CAPTURE
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); // RESP, stalled
      total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.rsp_valid); else pass_cnt++;
      total_cnt++; if (bus.rsp_data1 !== 9'h0A1 || bus.rsp_data2 !== 9'h13C) $display("FAIL bp_data[%0d]: got %h/%h expected 0a1/13c", i, bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
      total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b expected 0", i, bus.req_ready); else pass_cnt++;
      total_cnt++; if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) $display("FAIL bp_en[%0d]: got %h/%h expected 0000/0000", i, ReadEnable1, ReadEnable2); else pass_cnt++;
    end
    bus.rsp_ready = 1'b1;
    bus.req_addr1 = 4'd0; bus.req_addr2 = 4'd1;
    @(negedge clk); // IDLE
    total_cnt++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", bus.req_ready, bus.rsp_valid); else pass_cnt++;
    @(negedge clk); // DRIVE for the held request
    bus.req_valid = 1'b0;
    total_cnt++; if (ReadEnable1 !== 16'h0001 || ReadEnable2 !== 16'h0002) $display("FAIL bp_next_en: got %h/%h expected 0001/0002", ReadEnable1, ReadEnable2); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.rsp_data1 !== 9'h13C || bus.rsp_data2 !== 9'h0A1) $display("FAIL bp_next_data: got %h/%h expected 13c/0a1", bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send_req(4'd3, 4'd7);
    @(negedge clk); // CAPTURE
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) $display("FAIL rstmid_en: got %h/%h expected 0000/0000", ReadEnable1, ReadEnable2); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL rstmid_hs: got valid=%b ready=%b expected valid=0 ready=1", bus.rsp_valid, bus.req_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL rstmid_discard: got %b expected 0", bus.rsp_valid); else pass_cnt++;
    rst = 1'b0;
    send_req(4'd7, 4'd3);
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== 9'h05A || bus.rsp_data2 !== 9'h1A5) $display("FAIL rstmid_fresh: got valid=%b %h/%h expected valid=1 05a/1a5", bus.rsp_valid, bus.rsp_data1, bus.rsp_data2); else pass_cnt++;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr1 = '0;
    bus.req_addr2 = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_same_addr();
    test_capture_bypass();
    test_resp_write();
    test_drive_and_accept_write();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected sequence completion");
    $fatal(1, "watchdog expired");
  end
endmodule
